alu_result_display: RTL

- Downstream stage of the 8-bit ALU on the Basys3 board.
- Consumes the ALU's 8-bit result and carry flag, and converts the result to decimal BCD sequentially (double-dabble) or passes it through as hex.
- Drives the 4-digit multiplexed active-low seven-segment display, so operators can read the ALU output directly.

---
 rtl/alu_result_display.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result to 4-digit seven-segment display, sequential double-dabble BCD or hex.
module alu_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       hex_mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [4:0] BLANK = 5'h10;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      bin_q, bin_d;
  logic [7:0]      res_q, res_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            carry_q, carry_d;
  logic            hexm_q, hexm_d;
  logic [3:0][4:0] dig_q, dig_d;
  logic            disp_hex_q, disp_hex_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   ref_q, ref_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            busy_q, busy_d;
  logic [11:0]     adj;

  // Digit code: bit 4 set means blank, otherwise bits 3:0 select the glyph.
  function automatic logic [6:0] seg_code(input logic [4:0] d);
    logic [6:0] s;
    s = 7'h7F;
    if (!d[4]) begin
      case (d[3:0])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b0000011;
        4'hC: s = 7'b1000110;
        4'hD: s = 7'b0100001;
        4'hE: s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    res_d      = res_q;
    bcd_d      = bcd_q;
    carry_d    = carry_q;
    hexm_d     = hexm_q;
    dig_d      = dig_q;
    disp_hex_d = disp_hex_q;
    valid_d    = valid_q;

    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        res_d   = alu_result;
        bin_d   = alu_result;
        carry_d = alu_carry;
        hexm_d  = hex_mode;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        bcd_d = {adj[10:0], bin_q[7]};
        bin_d = {bin_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        dig_d[3]   = carry_q ? 5'h01 : BLANK;
        disp_hex_d = hexm_q;
        if (hexm_q) begin
          dig_d[2] = BLANK;
          dig_d[1] = {1'b0, res_q[7:4]};
          dig_d[0] = {1'b0, res_q[3:0]};
        end else begin
          dig_d[2] = (bcd_q[11:8] == 4'd0) ? BLANK : {1'b0, bcd_q[11:8]};
          dig_d[1] = (bcd_q[11:4] == 8'd0) ? BLANK : {1'b0, bcd_q[7:4]};
          dig_d[0] = {1'b0, bcd_q[3:0]};
        end
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ref_d = (ref_q == REF_LAST) ? '0 : ref_q + CW'(1);
    idx_d = (ref_q == REF_LAST) ? idx_q + 2'd1 : idx_q;

    // Outputs follow next-state index and digits so a wrap landing on COMMIT shows fresh data.
    an_d   = valid_d ? ~(4'b0001 << idx_d) : 4'hF;
    seg_d  = valid_d ? seg_code(dig_d[idx_d]) : 7'h7F;
    dp_d   = ~(valid_d & disp_hex_d & (idx_d == 2'd0));
    busy_d = (state_d == S_CONV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      res_q      <= '0;
      bcd_q      <= '0;
      carry_q    <= 1'b0;
      hexm_q     <= 1'b0;
      dig_q      <= '0;
      disp_hex_q <= 1'b0;
      valid_q    <= 1'b0;
      ref_q      <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= 4'hF;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      res_q      <= res_d;
      bcd_q      <= bcd_d;
      carry_q    <= carry_d;
      hexm_q     <= hexm_d;
      dig_q      <= dig_d;
      disp_hex_q <= disp_hex_d;
      valid_q    <= valid_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      busy_q     <= busy_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule
